// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the pixel-layer requesters, the shared sprite ROM and the arbiter.
// The arbiter uses the slave modport; requesters and ROM sit behind the master modport.
interface sprite_rom_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 12
);
   logic                     frame_start;
   logic [N_REQ-1:0]         req;
   logic [N_REQ*ADDR_W-1:0]  req_addr;
   logic [N_REQ-1:0]         gnt;
   logic                     rom_en;
   logic [ADDR_W-1:0]        rom_addr;
   logic [DATA_W-1:0]        rom_data;
   logic                     rsp_valid;
   logic [2:0]               rsp_id;
   logic [DATA_W-1:0]        rsp_data;
   logic [N_REQ-1:0]         starve;

   modport slave (
      input  frame_start, req, req_addr, rom_data,
      output gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, starve
   );

   modport master (
      output frame_start, req, req_addr, rom_data,
      input  gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, starve
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among N_REQ pixel layers.
// Optional build macro SPRITE_ARB_PRIO0_EN gives requester 0 fixed top priority.
module sprite_rom_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned ROM_LAT = 2
) (
   input logic              clock,
   input logic              reset,
   sprite_rom_arbiter_if.slave bus
);
   localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned ID_W   = 3;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned STAGES = ROM_LAT + 1;

   logic [PTR_W-1:0]                ptr_q, ptr_d;
   logic                            rom_en_q, rom_en_d;
   logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
   logic [STAGES-1:0]               tag_vld_q, tag_vld_d;
   logic [STAGES-1:0][ID_W-1:0]     tag_id_q, tag_id_d;
   logic                            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]                 rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]               rsp_data_q, rsp_data_d;
   logic [N_REQ-1:0]                starve_q, starve_d;
   logic [N_REQ-1:0][CNT_W-1:0]     wcnt_q, wcnt_d;

   logic [N_REQ-1:0]                gnt_c;
   logic                            found;
   logic                            prio_hit;
   logic [PTR_W-1:0]                gnt_idx;
   int unsigned                     idx;

   // Arbitration plus next-state for ROM port, tag pipeline, responses and starvation.
   always_comb begin
      gnt_c      = '0;
      found      = 1'b0;
      prio_hit   = 1'b0;
      gnt_idx    = '0;
      idx        = 0;
      ptr_d      = ptr_q;
      rom_addr_d = rom_addr_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      starve_d   = starve_q;
      wcnt_d     = wcnt_q;

      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && bus.req[PTR_W'(idx)]) begin
            found   = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
`ifdef SPRITE_ARB_PRIO0_EN
      if (bus.req[0]) begin
         found    = 1'b1;
         prio_hit = 1'b1;
         gnt_idx  = '0;
      end
`else
      prio_hit = 1'b0;
`endif
      if (reset) found = 1'b0;
      if (found) gnt_c[gnt_idx] = 1'b1;

      rom_en_d = found;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_c[i]) rom_addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
      if (found && !prio_hit) begin
         if (gnt_idx == PTR_W'(N_REQ - 1)) ptr_d = '0;
         else                              ptr_d = gnt_idx + PTR_W'(1);
      end
      if (bus.frame_start) ptr_d = '0;

      // Tag stage ROM_LAT lines up with the cycle rom_data is valid.
      tag_vld_d   = {tag_vld_q[STAGES-2:0], found};
      tag_id_d    = {tag_id_q[STAGES-2:0], ID_W'(gnt_idx)};
      rsp_valid_d = tag_vld_q[STAGES-1];
      if (tag_vld_q[STAGES-1]) begin
         rsp_id_d   = tag_id_q[STAGES-1];
         rsp_data_d = bus.rom_data;
      end

      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (wcnt_q[i] == CNT_W'(255)) starve_d[i] = 1'b1;
         if (!bus.req[i] || gnt_c[i])          wcnt_d[i] = '0;
         else if (wcnt_q[i] != CNT_W'(255))    wcnt_d[i] = wcnt_q[i] + CNT_W'(1);
      end
      if (bus.frame_start) starve_d = '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         starve_q    <= '0;
         wcnt_q      <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rom_en_q    <= rom_en_d;
         rom_addr_q  <= rom_addr_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         starve_q    <= starve_d;
         wcnt_q      <= wcnt_d;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.rom_en    = rom_en_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.starve    = starve_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a grant-order response scoreboard.
module tb_sprite_rom_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 14;
   localparam int unsigned DW = 12;

   typedef struct {
      logic [2:0]    id;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sbq[$];
   logic [DW-1:0] rom_p1, rom_p2;

   sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[11:0] ^ {8'h5A, a[13:12], 2'b01};
   endfunction

   // Two-cycle ROM model.
   always @(posedge clock) begin
      rom_p1 <= rom_f(bus.rom_addr);
      rom_p2 <= rom_p1;
   end
   assign bus.rom_data = rom_p2;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   // Compare returned words, then record this cycle's grant.
   task automatic sample();
      exp_t e;
      int   gid;
      @(negedge clock);
      if (!reset) begin
         if (bus.rsp_valid) begin
            if (sbq.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
               e = sbq.pop_front();
               chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
               chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
               chk("rsp_cycle", cyc, e.cyc);
            end
         end
         if (bus.gnt != '0) begin
            chk("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
            gid = 0;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gid = i;
            e.id   = 3'(gid);
            e.data = rom_f(bus.req_addr[gid*AW +: AW]);
            e.cyc  = cyc + 4;
            sbq.push_back(e);
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      bus.frame_start = 1'b0;
      bus.req         = 4'b1111;
      bus.req_addr    = {14'h03AA, 14'h02BC, 14'h0123, 14'h01F0};
      #3;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_starve", 32'(bus.starve), 32'd0);
      bus.req = '0;
      repeat (2) adv();
      reset = 1'b0;
      sample();

      // Single read from requester 1
      adv(); bus.req = 4'b0010; sample();
      chk("t1_gnt", 32'(bus.gnt), 32'b0010);
      adv(); bus.req = 4'b0000; sample();
      chk("t1_rom_en", 32'(bus.rom_en), 32'd1);
      chk("t1_rom_addr", 32'(bus.rom_addr), 32'h0123);
      chk("t1_gnt_idle", 32'(bus.gnt), 32'd0);
      adv(); sample();
      chk("t1_rom_en_off", 32'(bus.rom_en), 32'd0);
      chk("t1_rom_addr_hold", 32'(bus.rom_addr), 32'h0123);
      chk("t1_rsp_early2", 32'(bus.rsp_valid), 32'd0);
      adv(); sample();
      chk("t1_rsp_early3", 32'(bus.rsp_valid), 32'd0);
      adv(); sample();
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t1_rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("t1_rsp_data", 32'(bus.rsp_data), 32'(rom_f(14'h0123)));
      adv(); sample();
      chk("t1_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
      chk("t1_rsp_data_hold", 32'(bus.rsp_data), 32'(rom_f(14'h0123)));

`ifndef SPRITE_ARB_PRIO0_EN
      // Pointer sits at 2 after serving requester 1
      adv(); bus.req = 4'b0101; sample();
      chk("ptr2_gnt", 32'(bus.gnt), 32'b0100);
      // frame_start with ptr=3: this cycle still serves 3, next goes to 0
      adv(); bus.req = 4'b1111; bus.frame_start = 1'b1; sample();
      chk("fs_gnt", 32'(bus.gnt), 32'b1000);
      for (int k = 0; k < 8; k++) begin
         adv(); bus.frame_start = 1'b0; sample();
         chk("rr_all_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
         if (k == 0) chk("fs_starve", 32'(bus.starve), 32'd0);
      end
      // Move pointer to 1, then two requesters alternate
      adv(); bus.req = 4'b0001; sample();
      chk("ptr1_gnt", 32'(bus.gnt), 32'b0001);
      for (int k = 0; k < 4; k++) begin
         adv(); bus.req = 4'b1001; sample();
         chk("rr_1001_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'b1000 : 32'b0001);
      end
`else
      adv(); bus.req = 4'b0000; bus.frame_start = 1'b1; sample();
      for (int k = 0; k < 300; k++) begin
         adv(); bus.frame_start = 1'b0; bus.req = 4'b0101; sample();
         chk("prio_gnt", 32'(bus.gnt), 32'b0001);
         chk("prio_starve2", 32'(bus.starve[2]), (k >= 256) ? 32'd1 : 32'd0);
      end
      adv(); bus.frame_start = 1'b1; sample();
      adv(); bus.frame_start = 1'b0; sample();
      chk("prio_starve_clr", 32'(bus.starve), 32'd0);
`endif

      adv(); bus.req = 4'b0000; sample();
      for (int n = 0; n < 10 && sbq.size() != 0; n++) begin
         adv(); sample();
      end
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      // Reset two cycles after a grant discards in-flight reads
      adv(); bus.req = 4'b0001; sample();
      adv(); sample();
      adv(); sample();
      chk("pre_rst_rom_en", 32'(bus.rom_en), 32'd1);
      adv(); reset = 1'b1; bus.req = 4'b0000;
      #1;
      chk("mid_rst_rom_en", 32'(bus.rom_en), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      sbq.delete();
      adv(); adv(); reset = 1'b0;
      for (int n = 0; n < 8; n++) begin
         sample();
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
         adv();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
